lif_spike_decoder: RTL and testbench

Receive-side companion to the LIF neuron. It consumes the neuron's Q16.16 membrane-voltage sample stream and detects spikes, recognised as the reset-to-zero after a threshold crossing. Each spike is timestamped with its inter-spike interval (ISI) and queued as an event on a valid/ready output, for downstream rate-coding and readout logic.

---
 rtl/lif_pkg.sv | 28 ++
 rtl/lif_spike_decoder_if.sv | 24 ++
 rtl/lif_event_fifo.sv | 62 ++++++
 rtl/lif_spike_decoder.sv | 93 +++++++++
 tb/tb_lif_spike_decoder.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lif_pkg.sv
// Shared Q16.16 constants, event record and detection-state type for the LIF neuron blocks.
package lif_pkg;

    localparam logic signed [31:0] LIF_ONE         = 32'sh0001_0000;
    localparam logic signed [31:0] LIF_VTH         = 32'sh0000_FC93;
    localparam logic signed [31:0] LIF_ARM_DEFAULT = 32'sh0000_8000;

    typedef struct packed {
        logic [31:0] ts;
        logic [15:0] isi;
    } lif_event_t;

    typedef enum logic [0:0] {
        ST_DISARMED = 1'b0,
        ST_ARMED    = 1'b1
    } lif_state_t;

    // Interval since the previous spike; no previous spike or a gap past 16 bits reads as all-ones.
    function automatic logic [15:0] isi_sat(input logic [31:0] now, input logic [31:0] prev,
                                            input logic prev_vld);
        logic [31:0] diff;
        diff = now - prev;
        if (!prev_vld || diff > 32'h0000_FFFF)
            return 16'hFFFF;
        return diff[15:0];
    endfunction

endpackage

// File: rtl/lif_spike_decoder_if.sv
// Sample-in / event-out bundle between the membrane-voltage source, the spike decoder and its consumer.
interface lif_spike_decoder_if;

    logic signed [31:0] vin;
    logic               vin_valid;
    logic               ev_valid;
    logic               ev_ready;
    logic        [31:0] ev_ts;
    logic        [15:0] ev_isi;
    logic        [15:0] spike_cnt;
    logic        [15:0] drop_cnt;
    logic               ovf;

    modport slave (
        input  vin, vin_valid, ev_ready,
        output ev_valid, ev_ts, ev_isi, spike_cnt, drop_cnt, ovf
    );

    modport master (
        output vin, vin_valid, ev_ready,
        input  ev_valid, ev_ts, ev_isi, spike_cnt, drop_cnt, ovf
    );

endinterface

// File: rtl/lif_event_fifo.sv
// Spike-event queue; the head is read straight from storage flops, so a push is visible the cycle after.
module lif_event_fifo
    import lif_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  lif_event_t din,
    input  logic       pop,
    output lif_event_t head,
    output logic       full,
    output logic       empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    lif_event_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop_ok)
                count <= count + CNT_ONE;
            else if (!push_ok && pop_ok)
                count <= count - CNT_ONE;
        end
    end

endmodule

// File: rtl/lif_spike_decoder.sv
// Detects LIF spikes as the reset-to-zero after an armed sample and queues {ts, isi} events.
//   state       | meaning
//   ST_DISARMED | waiting for a sample at or above ARM_LEVEL
//   ST_ARMED    | last sample was at or above ARM_LEVEL; a zero sample is a spike
module lif_spike_decoder
    import lif_pkg::*;
#(
    parameter logic signed [31:0] ARM_LEVEL = LIF_ARM_DEFAULT,
    parameter int                 DEPTH     = 4
) (
    input logic                clk,
    input logic                rst,
    lif_spike_decoder_if.slave bus
);

    lif_state_t  state;
    logic [31:0] ts;
    logic [31:0] last_ts;
    logic        last_vld;
    logic [15:0] spike_cnt;
    logic [15:0] drop_cnt;
    logic        ovf;
    logic        at_arm;
    logic        spike;
    logic        pop;
    logic        full;
    logic        empty;
    logic        drop;
    lif_event_t  ev_new;
    lif_event_t  ev_head;

    assign at_arm = (bus.vin >= ARM_LEVEL);
    assign spike  = bus.vin_valid && (state == ST_ARMED) && (bus.vin == '0);
    assign pop    = !empty && bus.ev_ready;
    assign drop   = spike && full && !pop;
    assign ev_new = '{ts: ts, isi: isi_sat(ts, last_ts, last_vld)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_DISARMED;
        end else if (bus.vin_valid) begin
            case (state)
                ST_DISARMED: if (at_arm) state <= ST_ARMED;
                ST_ARMED:    if (bus.vin == '0 || !at_arm) state <= ST_DISARMED;
                default:     state <= ST_DISARMED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts        <= '0;
            last_ts   <= '0;
            last_vld  <= 1'b0;
            spike_cnt <= '0;
            drop_cnt  <= '0;
            ovf       <= 1'b0;
        end else begin
            if (bus.vin_valid)
                ts <= ts + 32'd1;
            // Spike bookkeeping runs whether or not the event finds room in the queue.
            if (spike) begin
                last_ts   <= ts;
                last_vld  <= 1'b1;
                spike_cnt <= spike_cnt + 16'd1;
            end
            if (drop) begin
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
                ovf <= 1'b1;
            end
        end
    end

    lif_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (spike),
        .din   (ev_new),
        .pop   (pop),
        .head  (ev_head),
        .full  (full),
        .empty (empty)
    );

    assign bus.ev_valid  = !empty;
    assign bus.ev_ts     = ev_head.ts;
    assign bus.ev_isi    = ev_head.isi;
    assign bus.spike_cnt = spike_cnt;
    assign bus.drop_cnt  = drop_cnt;
    assign bus.ovf       = ovf;

endmodule

// File: tb/tb_lif_spike_decoder.sv
// Directed and randomized bench for lif_spike_decoder against a sample-history event model.
module tb_lif_spike_decoder;
    import lif_pkg::*;

    localparam int                 DEPTH = 4;
    localparam logic signed [31:0] ARM   = LIF_ARM_DEFAULT;

    logic clk = 1'b0;
    logic rst = 1'b0;

    lif_spike_decoder_if bus ();

    lif_spike_decoder #(.ARM_LEVEL(ARM), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: a spike is a zero sample whose previous valid sample was at or above ARM.
    logic signed [31:0] m_prev;
    bit                 m_has_prev;
    logic [31:0]        m_ts;
    logic [31:0]        m_last;
    bit                 m_have_last;
    logic [47:0]        m_q[$];
    int                 m_spikes;
    int                 m_drops;
    bit                 m_ovf;
    bit                 rdy;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev      = '0;
        m_has_prev  = 1'b0;
        m_ts        = '0;
        m_last      = '0;
        m_have_last = 1'b0;
        m_q.delete();
        m_spikes    = 0;
        m_drops     = 0;
        m_ovf       = 1'b0;
    endtask

    task automatic model_cycle(input logic [31:0] v, input bit valid, input bit ready);
        bit          do_pop;
        bit          is_spike;
        int          sz;
        logic [31:0] d;
        logic [15:0] isi;
        sz       = m_q.size();
        do_pop   = ready && (sz > 0);
        is_spike = valid && m_has_prev && (m_prev >= ARM) && (v == 32'd0);
        if (valid) begin
            m_prev     = v;
            m_has_prev = 1'b1;
        end
        if (do_pop)
            void'(m_q.pop_front());
        if (is_spike) begin
            d   = m_ts - m_last;
            isi = (!m_have_last || d > 32'h0000_FFFF) ? 16'hFFFF : d[15:0];
            m_last      = m_ts;
            m_have_last = 1'b1;
            m_spikes++;
            if (sz == DEPTH && !do_pop) begin
                if (m_drops < 65535)
                    m_drops++;
                m_ovf = 1'b1;
            end else begin
                m_q.push_back({m_ts, isi});
            end
        end
        if (valid)
            m_ts++;
    endtask

    task automatic check_outputs();
        logic [15:0] sc;
        logic [15:0] dc;
        sc = m_spikes[15:0];
        dc = m_drops[15:0];
        chk("ev_valid", 48'(bus.ev_valid), 48'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("ev_ts", 48'(bus.ev_ts), 48'(m_q[0][47:16]));
            chk("ev_isi", 48'(bus.ev_isi), 48'(m_q[0][15:0]));
        end
        chk("spike_cnt", 48'(bus.spike_cnt), 48'(sc));
        chk("drop_cnt", 48'(bus.drop_cnt), 48'(dc));
        chk("ovf", 48'(bus.ovf), 48'(m_ovf));
    endtask

    task automatic step(input logic [31:0] v, input bit valid, input bit ready);
        @(negedge clk);
        bus.vin       = valid ? v : 'x;
        bus.vin_valid = valid;
        bus.ev_ready  = ready;
        model_cycle(v, valid, ready);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic sample(input logic [31:0] v);
        step(v, 1'b1, rdy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(32'd0, 1'b0, rdy);
    endtask

    task automatic fire();
        sample(32'h0000_4000);
        sample(32'h0000_9000);
        sample(32'h0000_F000);
        sample(32'h0000_0000);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ev_valid"}, 48'(bus.ev_valid), 48'(0));
        chk({tag, "_ev_ts"}, 48'(bus.ev_ts), 48'(0));
        chk({tag, "_ev_isi"}, 48'(bus.ev_isi), 48'(0));
        chk({tag, "_spike_cnt"}, 48'(bus.spike_cnt), 48'(0));
        chk({tag, "_drop_cnt"}, 48'(bus.drop_cnt), 48'(0));
        chk({tag, "_ovf"}, 48'(bus.ovf), 48'(0));
    endtask

    function automatic logic [31:0] rand_sample();
        case ($urandom_range(0, 7))
            0, 1:    return 32'h0000_0000;
            2:       return ARM;
            3:       return ARM - 32'sd1;
            4:       return 32'hFFFF_0000;
            5:       return 32'h0001_0000;
            6:       return 32'h0000_9000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] exp_ts[3];
        logic [15:0] exp_isi[3];
        logic [31:0] rv;
        bit          rvalid;
        exp_ts  = '{32'd3, 32'd7, 32'd11};
        exp_isi = '{16'hFFFF, 16'd4, 16'd4};

        bus.vin       = '0;
        bus.vin_valid = 1'b0;
        bus.ev_ready  = 1'b0;
        rdy           = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b1;

        // Single spike, then two more at period 4.
        fire();
        chk("single_ev_valid", 48'(bus.ev_valid), 48'(1));
        chk("single_ev_ts", 48'(bus.ev_ts), 48'(3));
        chk("single_ev_isi", 48'(bus.ev_isi), 48'(16'hFFFF));
        chk("single_spike_cnt", 48'(bus.spike_cnt), 48'(1));
        fire();
        fire();
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("periodic_ts", 48'(bus.ev_ts), 48'(exp_ts[i]));
            chk("periodic_isi", 48'(bus.ev_isi), 48'(exp_isi[i]));
            idle(1);
        end
        chk("periodic_drained", 48'(bus.ev_valid), 48'(0));

        // Sub-arm and negative samples disarm without a spike.
        sample(32'h0000_9000);
        sample(32'h0000_2000);
        sample(32'h0000_0000);
        sample(32'hFFFF_0000);
        sample(32'h0000_0000);
        sample(32'h0000_9000);
        sample(32'hFFFF_0000);
        sample(32'h0000_0000);
        idle(2);
        chk("no_false_spike_cnt", 48'(bus.spike_cnt), 48'(3));

        // Backpressure: six spikes into four slots.
        rdy = 1'b0;
        repeat (6) fire();
        idle(5);
        chk("bp_drop_cnt", 48'(bus.drop_cnt), 48'(2));
        chk("bp_ovf", 48'(bus.ovf), 48'(1));
        chk("bp_spike_cnt", 48'(bus.spike_cnt), 48'(9));
        rdy = 1'b1;
        idle(4);
        chk("bp_drained", 48'(bus.ev_valid), 48'(0));

        // Asynchronous reset with two events queued.
        rdy = 1'b0;
        fire();
        fire();
        #2;
        rst = 1'b0;
        bus.vin_valid = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(3);

        // Full queue, spike coincides with a pop.
        repeat (4) fire();
        sample(32'h0000_4000);
        sample(32'h0000_9000);
        sample(32'h0000_F000);
        step(32'h0000_0000, 1'b1, 1'b1);
        chk("pp_full_drop_cnt", 48'(bus.drop_cnt), 48'(0));
        rdy = 1'b1;
        idle(4);
        chk("pp_full_drained", 48'(bus.ev_valid), 48'(0));

        // ISI saturation just past 16 bits, then minimum spacing of 2.
        fire();
        for (int i = 0; i < 65534; i++)
            sample(32'h0000_0000);
        rdy = 1'b0;
        sample(32'h0000_9000);
        sample(32'h0000_0000);
        chk("isi_saturated", 48'(bus.ev_isi), 48'(16'hFFFF));
        sample(32'h0000_9000);
        sample(32'h0000_0000);
        step(32'd0, 1'b0, 1'b1);
        chk("isi_min_spacing", 48'(bus.ev_isi), 48'(2));
        step(32'd0, 1'b0, 1'b1);

        // Random samples, strobes and backpressure.
        for (int i = 0; i < 1500; i++) begin
            rv     = rand_sample();
            rvalid = ($urandom_range(0, 3) != 0);
            step(rv, rvalid, ($urandom_range(0, 2) == 0));
        end
        rdy = 1'b1;
        idle(DEPTH + 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
